// File: rtl/hba_seq_pkg.sv
// Shared opcodes, FSM encodings and command field layout for the HBA master sequencer.
// Command word, MSB first: {op, core, reg, data, mask}.
package hba_seq_pkg;

  localparam int unsigned OpWidth      = 3;
  localparam int unsigned MaskFieldLsb = 0;

  typedef enum logic [2:0] {
    OpEnd   = 3'd0,
    OpWrite = 3'd1,
    OpRead  = 3'd2,
    OpPoll  = 3'd3,
    OpWait  = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StXfer,
    StDelay,
    StDone,
    StError
  } seq_state_e;

  typedef enum logic [1:0] {
    MstIdle,
    MstReq,
    MstXfer
  } mst_state_e;

  function automatic int unsigned data_field_lsb(int unsigned dbus_width);
    return dbus_width;
  endfunction

  // The reg field sits directly above data; core sits above reg, so {core, reg} is the bus address.
  function automatic int unsigned reg_field_lsb(int unsigned dbus_width);
    return 2 * dbus_width;
  endfunction

  function automatic int unsigned op_field_lsb(int unsigned dbus_width, int unsigned addr_width);
    return 2 * dbus_width + addr_width;
  endfunction

endpackage

// File: rtl/hba_master.sv
// Single-transaction HBA bus master: request, wait for grant, drive the cycle until xferack.
// Bus outputs are all zero whenever no transaction is in flight.
module hba_master
  import hba_seq_pkg::*;
#(
  parameter int unsigned AddrWidth = 12,
  parameter int unsigned DataWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 app_en_strobe_i,
  input  logic                 app_rnw_i,
  input  logic [AddrWidth-1:0] app_addr_i,
  input  logic [DataWidth-1:0] app_wdata_i,
  output logic                 app_valid_o,
  output logic [DataWidth-1:0] app_rdata_o,
  output logic                 hba_mrequest_o,
  input  logic                 hba_mgrant_i,
  output logic [AddrWidth-1:0] hba_abus_o,
  output logic                 hba_rnw_o,
  output logic                 hba_select_o,
  output logic [DataWidth-1:0] hba_dbus_o,
  input  logic                 hba_xferack_i,
  input  logic [DataWidth-1:0] hba_dbus_i
);

  mst_state_e           state_q, state_d;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] wdata_q;
  logic [DataWidth-1:0] rdata_q;
  logic                 rnw_q;
  logic                 valid_q;
  logic                 xfer_done;

  assign xfer_done = (state_q == MstXfer) && hba_xferack_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      MstIdle: if (app_en_strobe_i) state_d = MstReq;
      MstReq:  if (hba_mgrant_i)    state_d = MstXfer;
      MstXfer: if (hba_xferack_i)   state_d = MstIdle;
      default: state_d = MstIdle;
    endcase
  end

  // Active-high reset so the bus drops as soon as the system reset is asserted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= MstIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rnw_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= xfer_done;
      if ((state_q == MstIdle) && app_en_strobe_i) begin
        addr_q  <= app_addr_i;
        wdata_q <= app_wdata_i;
        rnw_q   <= app_rnw_i;
      end
      if (xfer_done && rnw_q) begin
        rdata_q <= hba_dbus_i;
      end
    end
  end

  assign app_valid_o    = valid_q;
  assign app_rdata_o    = rdata_q;
  assign hba_mrequest_o = (state_q != MstIdle);
  assign hba_select_o   = (state_q == MstXfer);
  assign hba_abus_o     = hba_select_o ? addr_q : '0;
  assign hba_rnw_o      = hba_select_o & rnw_q;
  assign hba_dbus_o     = (hba_select_o && !rnw_q) ? wdata_q : '0;

endmodule

// File: rtl/hba_master_seq.sv
// Command-ROM driven sequencer issuing WRITE/READ/POLL/WAIT operations over the HBA master port.
// Sequencing lives here; the bus handshake is delegated to hba_master.
module hba_master_seq
  import hba_seq_pkg::*;
#(
  parameter int unsigned DBUS_WIDTH        = 8,
  parameter int unsigned PERIPH_ADDR_WIDTH = 4,
  parameter int unsigned REG_ADDR_WIDTH    = 8,
  parameter int unsigned PC_WIDTH          = 6,
  parameter int unsigned POLL_LIMIT        = 255,
  localparam int unsigned ADDR_WIDTH       = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  localparam int unsigned CMD_WIDTH        = OpWidth + ADDR_WIDTH + 2 * DBUS_WIDTH
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset_n,
  input  logic [DBUS_WIDTH-1:0] hba_dbus,
  input  logic                  hba_xferack,
  input  logic                  hba_mgrant,
  output logic                  hba_mrequest,
  output logic [ADDR_WIDTH-1:0] hba_abus_master,
  output logic                  hba_rnw_master,
  output logic                  hba_select_master,
  output logic [DBUS_WIDTH-1:0] hba_dbus_master,
  input  logic                  seq_start,
  output logic [PC_WIDTH-1:0]   seq_pc,
  input  logic [CMD_WIDTH-1:0]  seq_cmd,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic                  seq_error,
  output logic [DBUS_WIDTH-1:0] seq_rdata
);

  localparam int unsigned DataLsb = data_field_lsb(DBUS_WIDTH);
  localparam int unsigned RegLsb  = reg_field_lsb(DBUS_WIDTH);
  localparam int unsigned OpLsb   = op_field_lsb(DBUS_WIDTH, ADDR_WIDTH);
  localparam int unsigned PollW   = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;

  localparam logic [PollW-1:0]      PollLast = PollW'(POLL_LIMIT - 1);
  localparam logic [PollW-1:0]      PollOne  = PollW'(1);
  localparam logic [PC_WIDTH-1:0]   PcMax    = '1;
  localparam logic [PC_WIDTH-1:0]   PcOne    = PC_WIDTH'(1);
  localparam logic [DBUS_WIDTH-1:0] CntOne   = DBUS_WIDTH'(1);

  logic [1:0]            rst_sync_q;
  logic                  rst_n_sync;
  seq_state_e            state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
  logic [DBUS_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic [PollW-1:0]      poll_cnt_q, poll_cnt_d;
  logic [DBUS_WIDTH-1:0] rdata_q, rdata_d;
  logic                  start_q;
  logic                  start_rise;
  logic                  advance;
  logic                  app_en_strobe;
  logic                  app_valid_out;
  logic [DBUS_WIDTH-1:0] app_rdata;
  op_e                   op;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DBUS_WIDTH-1:0] cmd_data;
  logic [DBUS_WIDTH-1:0] cmd_mask;
  logic                  poll_match;

  // Assertion is asynchronous; release is retimed through two flops.
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n_sync = rst_sync_q[1];

  assign op         = op_e'(cmd_q[OpLsb +: OpWidth]);
  assign cmd_addr   = cmd_q[RegLsb +: ADDR_WIDTH];
  assign cmd_data   = cmd_q[DataLsb +: DBUS_WIDTH];
  assign cmd_mask   = cmd_q[MaskFieldLsb +: DBUS_WIDTH];
  assign poll_match = ((app_rdata ^ cmd_data) & cmd_mask) == '0;
  assign start_rise = seq_start & ~start_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    cmd_d         = cmd_q;
    wait_cnt_d    = wait_cnt_q;
    poll_cnt_d    = poll_cnt_q;
    rdata_d       = rdata_q;
    app_en_strobe = 1'b0;
    advance       = 1'b0;

    case (state_q)
      StIdle, StDone, StError: begin
        if (start_rise) begin
          pc_d    = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        cmd_d   = seq_cmd;
        state_d = StDecode;
      end
      StDecode: begin
        poll_cnt_d = '0;
        unique case (op)
          OpWrite, OpRead, OpPoll: begin
            app_en_strobe = 1'b1;
            state_d       = StXfer;
          end
          OpWait: begin
            wait_cnt_d = cmd_data;
            state_d    = StDelay;
          end
          OpEnd:   state_d = StDone;
          default: state_d = StError;
        endcase
      end
      StXfer: begin
        if (app_valid_out) begin
          if (op != OpWrite) begin
            rdata_d = app_rdata;
          end
          if (op != OpPoll || poll_match) begin
            advance = 1'b1;
          end else if (poll_cnt_q == PollLast) begin
            state_d = StError;
          end else begin
            // Re-issue the same POLL read; only one transaction is ever outstanding.
            poll_cnt_d    = poll_cnt_q + PollOne;
            app_en_strobe = 1'b1;
          end
        end
      end
      StDelay: begin
        if (wait_cnt_q == '0) begin
          advance = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - CntOne;
        end
      end
      default: state_d = StIdle;
    endcase

    // Running off the end of the ROM is a fault; pc stays on the last command.
    if (advance) begin
      if (pc_q == PcMax) begin
        state_d = StError;
      end else begin
        pc_d    = pc_q + PcOne;
        state_d = StFetch;
      end
    end
  end

  always_ff @(posedge hba_clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      cmd_q      <= '0;
      wait_cnt_q <= '0;
      poll_cnt_q <= '0;
      rdata_q    <= '0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cmd_q      <= cmd_d;
      wait_cnt_q <= wait_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      rdata_q    <= rdata_d;
      start_q    <= seq_start;
    end
  end

  assign seq_pc    = pc_q;
  assign seq_rdata = rdata_q;
  assign seq_done  = (state_q == StDone);
  assign seq_error = (state_q == StError);
  assign seq_busy  = (state_q == StFetch) || (state_q == StDecode) ||
                     (state_q == StXfer)  || (state_q == StDelay);

  hba_master #(
    .AddrWidth (ADDR_WIDTH),
    .DataWidth (DBUS_WIDTH)
  ) u_hba_master (
    .clk_i           (hba_clk),
    .rst_i           (~hba_reset_n),
    .app_en_strobe_i (app_en_strobe),
    .app_rnw_i       (op != OpWrite),
    .app_addr_i      (cmd_addr),
    .app_wdata_i     (cmd_data),
    .app_valid_o     (app_valid_out),
    .app_rdata_o     (app_rdata),
    .hba_mrequest_o  (hba_mrequest),
    .hba_mgrant_i    (hba_mgrant),
    .hba_abus_o      (hba_abus_master),
    .hba_rnw_o       (hba_rnw_master),
    .hba_select_o    (hba_select_master),
    .hba_dbus_o      (hba_dbus_master),
    .hba_xferack_i   (hba_xferack),
    .hba_dbus_i      (hba_dbus)
  );

endmodule

// File: tb/tb_hba_master_seq.sv
// Bench for hba_master_seq: combinational command ROM, randomly stalling HBA slave with memory,
// and a program-level reference model of the expected bus transactions and final status.
module tb_hba_master_seq;

  localparam int DW    = 8;
  localparam int AW    = 12;
  localparam int CW    = 3 + AW + 2 * DW;
  localparam int PCW   = 6;
  localparam int DEPTH = 64;
  localparam int LIM   = 4;

  typedef struct packed {
    logic          rnw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } xact_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [DW-1:0]  hba_dbus;
  logic           hba_xferack;
  logic           hba_mgrant;
  logic           hba_mrequest;
  logic [AW-1:0]  hba_abus_master;
  logic           hba_rnw_master;
  logic           hba_select_master;
  logic [DW-1:0]  hba_dbus_master;
  logic           seq_start;
  logic [PCW-1:0] seq_pc;
  logic [CW-1:0]  seq_cmd;
  logic           seq_busy;
  logic           seq_done;
  logic           seq_error;
  logic [DW-1:0]  seq_rdata;

  logic [CW-1:0]  rom [DEPTH];
  logic [DW-1:0]  mem [1 << AW];
  logic [DW-1:0]  model_mem [1 << AW];
  logic [DW-1:0]  resp_q[$];
  logic [DW-1:0]  model_resp[$];
  xact_t          log_q[$];
  xact_t          exp_q[$];
  logic [DW-1:0]  m_rdata;
  bit             m_err;
  int             m_pc;
  int             tests = 0;
  int             fails = 0;

  always #5 clk = ~clk;
  assign seq_cmd = rom[seq_pc];

  hba_master_seq #(
    .DBUS_WIDTH        (DW),
    .PERIPH_ADDR_WIDTH (4),
    .REG_ADDR_WIDTH    (8),
    .PC_WIDTH          (PCW),
    .POLL_LIMIT        (LIM)
  ) dut (
    .hba_clk           (clk),
    .hba_reset_n       (rst_n),
    .hba_dbus          (hba_dbus),
    .hba_xferack       (hba_xferack),
    .hba_mgrant        (hba_mgrant),
    .hba_mrequest      (hba_mrequest),
    .hba_abus_master   (hba_abus_master),
    .hba_rnw_master    (hba_rnw_master),
    .hba_select_master (hba_select_master),
    .hba_dbus_master   (hba_dbus_master),
    .seq_start         (seq_start),
    .seq_pc            (seq_pc),
    .seq_cmd           (seq_cmd),
    .seq_busy          (seq_busy),
    .seq_done          (seq_done),
    .seq_error         (seq_error),
    .seq_rdata         (seq_rdata)
  );

  // Slave: random grant and ack stalls; reads come from resp_q when loaded, else from mem.
  initial begin
    logic [DW-1:0] v;
    hba_mgrant  = 1'b0;
    hba_xferack = 1'b0;
    hba_dbus    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hba_mgrant  = 1'b0;
        hba_xferack = 1'b0;
        hba_dbus    = '0;
      end else begin
        hba_mgrant = hba_mrequest && ($urandom_range(0, 2) != 0);
        if (hba_xferack) begin
          hba_xferack = 1'b0;
          hba_dbus    = '0;
        end else if (hba_select_master && ($urandom_range(0, 2) != 0)) begin
          if (hba_rnw_master) begin
            v = (resp_q.size() > 0) ? resp_q.pop_front() : mem[hba_abus_master];
            hba_dbus = v;
            log_q.push_back({1'b1, hba_abus_master, v});
          end else begin
            mem[hba_abus_master] = hba_dbus_master;
            log_q.push_back({1'b0, hba_abus_master, hba_dbus_master});
          end
          hba_xferack = 1'b1;
        end
      end
    end
  end

  function automatic logic [CW-1:0] mk(int op, int core, int rg, int data, int mask);
    return {3'(op), 4'(core), 8'(rg), 8'(data), 8'(mask)};
  endfunction

  function automatic logic [DW-1:0] model_read(logic [AW-1:0] a);
    if (model_resp.size() > 0) return model_resp.pop_front();
    return model_mem[a];
  endfunction

  function automatic bit logs_match();
    if (log_q.size() != exp_q.size()) return 1'b0;
    foreach (log_q[i]) if (log_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic rom_fill(input logic [CW-1:0] c);
    for (int i = 0; i < DEPTH; i++) rom[i] = c;
  endtask

  // Interprets the ROM program directly: expected transactions, final rdata, outcome, stop pc.
  task automatic model_run();
    int            pc;
    int            misses;
    bit            fin;
    logic [2:0]    op;
    logic [AW-1:0] a;
    logic [DW-1:0] d, mk_v, v;
    exp_q.delete();
    model_mem  = mem;
    model_resp = resp_q;
    pc    = 0;
    fin   = 1'b0;
    m_err = 1'b0;
    while (!fin) begin
      {op, a, d, mk_v} = rom[pc];
      case (op)
        3'd0: fin = 1'b1;
        3'd1: begin
          exp_q.push_back({1'b0, a, d});
          model_mem[a] = d;
        end
        3'd2: begin
          v = model_read(a);
          exp_q.push_back({1'b1, a, v});
          m_rdata = v;
        end
        3'd3: begin
          misses = 0;
          forever begin
            v = model_read(a);
            exp_q.push_back({1'b1, a, v});
            m_rdata = v;
            if (((v ^ d) & mk_v) == 0) break;
            misses++;
            if (misses == LIM) begin
              m_err = 1'b1;
              fin   = 1'b1;
              break;
            end
          end
        end
        3'd4: ;
        default: begin
          m_err = 1'b1;
          fin   = 1'b1;
        end
      endcase
      if (!fin) begin
        if (pc == DEPTH - 1) begin
          m_err = 1'b1;
          fin   = 1'b1;
        end else begin
          pc++;
        end
      end
    end
    m_pc = pc;
  endtask

  task automatic run_prog(output int busy, output bit saw_req);
    int n;
    log_q.delete();
    busy    = 0;
    saw_req = 1'b0;
    @(negedge clk);
    seq_start = 1'b1;
    @(negedge clk);
    seq_start = 1'b0;
    n = 0;
    while (!(seq_done || seq_error) && n < 5000) begin
      if (seq_busy) busy++;
      if (hba_mrequest) saw_req = 1'b1;
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 5000) begin
      fails++;
      $display("FAIL run_timeout: still busy after %0d cycles, want done or error", n);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    seq_start = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({seq_busy, seq_done, seq_error, seq_pc, seq_rdata} !== '0) begin
      fails++;
      $display("FAIL reset_seq: got busy=%b done=%b err=%b pc=%0d rdata=%h, want all 0",
               seq_busy, seq_done, seq_error, seq_pc, seq_rdata);
    end
    tests++;
    if ({hba_mrequest, hba_select_master, hba_rnw_master, hba_abus_master, hba_dbus_master}
        !== '0) begin
      fails++;
      $display("FAIL reset_bus: got req=%b sel=%b abus=%h dbus=%h, want all 0",
               hba_mrequest, hba_select_master, hba_abus_master, hba_dbus_master);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    tests++;
    if ({seq_busy, seq_done, seq_error, hba_mrequest} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b done=%b err=%b req=%b, want idle without start",
               seq_busy, seq_done, seq_error, hba_mrequest);
    end
    m_rdata = '0;
  endtask

  task automatic test_write();
    int busy;
    bit req;
    rom_fill(mk(0, 0, 0, 0, 0));
    rom[0] = mk(1, 1, 0, 8'h01, 0);
    resp_q.delete();
    model_run();
    run_prog(busy, req);
    tests++;
    if (log_q.size() != 1 || log_q[0] !== {1'b0, 12'h100, 8'h01}) begin
      fails++;
      $display("FAIL write_xact: got %0d xacts first=%h, want one write 100<=01",
               log_q.size(), (log_q.size() > 0) ? log_q[0] : '0);
    end
    repeat (5) @(negedge clk);
    tests++;
    if ({seq_done, seq_error, seq_busy} !== 3'b100) begin
      fails++;
      $display("FAIL write_status: got done=%b err=%b busy=%b, want done held",
               seq_done, seq_error, seq_busy);
    end
  endtask

  task automatic test_read();
    int busy;
    bit req;
    rom_fill(mk(0, 0, 0, 0, 0));
    rom[0] = mk(2, 2, 3, 0, 0);
    resp_q = '{8'hA5};
    model_run();
    run_prog(busy, req);
    tests++;
    if (seq_rdata !== 8'hA5 || !seq_done || seq_error) begin
      fails++;
      $display("FAIL read_rdata: got rdata=%h done=%b err=%b, want A5 done",
               seq_rdata, seq_done, seq_error);
    end
    tests++;
    if (log_q.size() != 1 || log_q[0] !== {1'b1, 12'h203, 8'hA5}) begin
      fails++;
      $display("FAIL read_xact: got %0d xacts, want one read of 203", log_q.size());
    end
  endtask

  task automatic test_poll();
    int busy;
    bit req;
    rom_fill(mk(0, 0, 0, 0, 0));
    rom[0] = mk(3, 4, 0, 8'h80, 8'h80);
    resp_q = '{8'h00, 8'h00, 8'h80};
    model_run();
    run_prog(busy, req);
    tests++;
    if (log_q.size() != 3 || !seq_done || seq_error || seq_rdata !== 8'h80) begin
      fails++;
      $display("FAIL poll_match: got reads=%0d done=%b err=%b rdata=%h, want 3 reads done 80",
               log_q.size(), seq_done, seq_error, seq_rdata);
    end
  endtask

  task automatic test_poll_limit();
    int busy;
    bit req;
    rom_fill(mk(0, 0, 0, 0, 0));
    rom[0] = mk(1, 5, 1, 8'h33, 0);
    rom[1] = mk(4, 0, 0, 2, 0);
    rom[2] = mk(3, 4, 0, 8'h80, 8'h80);
    mem[12'h400] = 8'h00;
    resp_q.delete();
    model_run();
    run_prog(busy, req);
    tests++;
    if (log_q.size() != 1 + LIM || !seq_error || seq_done) begin
      fails++;
      $display("FAIL poll_limit: got xacts=%0d err=%b done=%b, want %0d xacts and error",
               log_q.size(), seq_error, seq_done, 1 + LIM);
    end
    tests++;
    if (seq_pc !== 6'd2) begin
      fails++;
      $display("FAIL poll_limit_pc: got pc=%0d, want 2", seq_pc);
    end
  endtask

  task automatic test_wait();
    int busy;
    bit req;
    rom_fill(mk(0, 0, 0, 0, 0));
    rom[0] = mk(4, 0, 0, 9, 0);
    resp_q.delete();
    run_prog(busy, req);
    // 2 cycles fetch/decode per command plus data+1 idle cycles for the WAIT.
    tests++;
    if (busy != 14 || req || !seq_done) begin
      fails++;
      $display("FAIL wait_cycles: got busy=%0d req_seen=%b done=%b, want 14 no request done",
               busy, req, seq_done);
    end
  endtask

  task automatic test_illegal();
    int busy;
    bit req;
    rom_fill(mk(0, 0, 0, 0, 0));
    rom[0] = mk(6, 1, 2, 3, 4);
    run_prog(busy, req);
    tests++;
    if (!seq_error || seq_done || seq_pc !== 6'd0 || busy != 2) begin
      fails++;
      $display("FAIL illegal_op6: got err=%b done=%b pc=%0d busy=%0d, want error at pc 0 busy 2",
               seq_error, seq_done, seq_pc, busy);
    end
    rom[0] = mk(4, 0, 0, 0, 0);
    rom[1] = mk(4, 0, 0, 0, 0);
    rom[2] = mk(4, 0, 0, 0, 0);
    rom[3] = mk(7, 0, 0, 0, 0);
    run_prog(busy, req);
    tests++;
    if (!seq_error || seq_pc !== 6'd3) begin
      fails++;
      $display("FAIL illegal_op7: got err=%b pc=%0d, want error at pc 3", seq_error, seq_pc);
    end
  endtask

  task automatic test_overrun();
    int busy;
    bit req;
    rom_fill(mk(4, 0, 0, 0, 0));
    run_prog(busy, req);
    tests++;
    if (!seq_error || seq_pc !== 6'd63 || busy != 3 * DEPTH) begin
      fails++;
      $display("FAIL overrun: got err=%b pc=%0d busy=%0d, want error at pc 63 busy %0d",
               seq_error, seq_pc, busy, 3 * DEPTH);
    end
  endtask

  task automatic test_busy_ignore();
    int busy;
    bit req;
    rom_fill(mk(0, 0, 0, 0, 0));
    rom[0] = mk(1, 3, 7, 8'h11, 0);
    rom[1] = mk(4, 0, 0, 20, 0);
    rom[2] = mk(1, 3, 8, 8'h22, 0);
    resp_q.delete();
    model_run();
    fork
      begin
        repeat (8) @(negedge clk);
        seq_start = 1'b1;
        @(negedge clk);
        seq_start = 1'b0;
      end
    join_none
    run_prog(busy, req);
    tests++;
    if (logs_match() !== 1'b1 || !seq_done) begin
      fails++;
      $display("FAIL busy_ignore: got xacts=%0d done=%b, want %0d xacts done",
               log_q.size(), seq_done, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int busy;
    bit req;
    rom_fill(mk(0, 0, 0, 0, 0));
    rom[0] = mk(1, 1, 8'hAB, 8'h5C, 0);
    rom[1] = mk(2, 2, 1, 0, 0);
    resp_q.delete();
    @(negedge clk);
    seq_start = 1'b1;
    @(negedge clk);
    seq_start = 1'b0;
    n = 0;
    while (!(hba_select_master && hba_rnw_master) && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 200) begin
      fails++;
      $display("FAIL reset_mid_wait: read select not seen in %0d cycles", n);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({hba_mrequest, hba_select_master, hba_rnw_master, hba_abus_master, hba_dbus_master,
         seq_busy, seq_done, seq_error, seq_pc, seq_rdata} !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got req=%b sel=%b abus=%h busy=%b pc=%0d rdata=%h, want 0",
               hba_mrequest, hba_select_master, hba_abus_master, seq_busy, seq_pc, seq_rdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    m_rdata = '0;
    model_run();
    run_prog(busy, req);
    tests++;
    if (logs_match() !== 1'b1 || seq_rdata !== m_rdata || !seq_done) begin
      fails++;
      $display("FAIL reset_mid_rerun: got xacts=%0d rdata=%h done=%b, want %0d xacts rdata=%h",
               log_q.size(), seq_rdata, seq_done, exp_q.size(), m_rdata);
    end
  endtask

  task automatic test_random();
    int busy;
    bit req;
    int len;
    int r;
    int op;
    for (int it = 0; it < 25; it++) begin
      rom_fill(mk(0, 0, 0, 0, 0));
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        r  = $urandom_range(0, 19);
        op = (r < 5) ? 1 : (r < 10) ? 2 : (r < 14) ? 3 : (r < 18) ? 4 :
             (r == 18) ? $urandom_range(5, 7) : 0;
        rom[i] = mk(op, $urandom_range(0, 15), $urandom_range(0, 3),
                    (op == 4) ? $urandom_range(0, 6) : $urandom_range(0, 255),
                    (op == 3 && $urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 255));
      end
      resp_q.delete();
      model_run();
      run_prog(busy, req);
      tests++;
      if (logs_match() !== 1'b1) begin
        fails++;
        $display("FAIL rand_xacts[%0d]: got %0d xacts, want %0d", it, log_q.size(), exp_q.size());
      end
      tests++;
      if (seq_error !== m_err || seq_done !== !m_err) begin
        fails++;
        $display("FAIL rand_status[%0d]: got done=%b err=%b, want err=%b",
                 it, seq_done, seq_error, m_err);
      end
      tests++;
      if (seq_rdata !== m_rdata) begin
        fails++;
        $display("FAIL rand_rdata[%0d]: got %h, want %h", it, seq_rdata, m_rdata);
      end
      if (m_err) begin
        tests++;
        if (seq_pc !== PCW'(m_pc)) begin
          fails++;
          $display("FAIL rand_err_pc[%0d]: got %0d, want %0d", it, seq_pc, m_pc);
        end
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    seq_start = 1'b0;
    rom_fill('0);
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'($urandom);
    test_reset();
    test_write();
    test_read();
    test_poll();
    test_poll_limit();
    test_wait();
    test_illegal();
    test_overrun();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
